// File: rtl/fetch_unit_pkg.sv
// Shared decoder/fetch definitions: branch-kind codes, fetch FSM states, and the taken rule.
package fetch_unit_pkg;

    localparam int unsigned LUT_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        BR_NONE     = 2'b00,
        BR_IF_COND  = 2'b01,
        BR_IF_NCOND = 2'b10,
        BR_ALWAYS   = 2'b11
    } branch_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } fetch_state_e;

    function automatic logic branch_taken(input logic [1:0] kind, input logic cond);
        logic taken;
        case (branch_e'(kind))
            BR_ALWAYS:   taken = 1'b1;
            BR_IF_COND:  taken = cond;
            BR_IF_NCOND: taken = ~cond;
            default:     taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target table: label number from the assembler to absolute ROM address.
module branch_lut
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned LUT_W = LUT_W_DEFAULT
) (
    input  logic [LUT_W-1:0] idx,
    output logic [PC_W-1:0]  addr
);

    // Entries wider than PC_W are truncated to the ROM address space.
    always_comb begin
        addr = '0;
        case (idx)
            LUT_W'(0):  addr = PC_W'(0);
            LUT_W'(1):  addr = PC_W'(20);
            LUT_W'(2):  addr = PC_W'(40);
            LUT_W'(3):  addr = PC_W'(8);
            LUT_W'(4):  addr = PC_W'(14);
            LUT_W'(5):  addr = PC_W'(3);
            LUT_W'(6):  addr = PC_W'(100);
            LUT_W'(7):  addr = PC_W'(1023);
            LUT_W'(8):  addr = PC_W'(512);
            LUT_W'(9):  addr = PC_W'(5);
            LUT_W'(10): addr = PC_W'(17);
            LUT_W'(11): addr = PC_W'(1);
            LUT_W'(12): addr = PC_W'(200);
            LUT_W'(13): addr = PC_W'(300);
            LUT_W'(14): addr = PC_W'(7);
            LUT_W'(15): addr = PC_W'(1000);
            default:    addr = '0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC register plus IDLE/RUN/DONE control.
//   state   | meaning
//   IDLE    | waiting for start, pc=0
//   RUN     | fetching, pc advances unless stalled
//   DONE    | PROG_END fetched, pc frozen, done held until start
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned PROG_END = 1023,
    parameter int unsigned LUT_W    = LUT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic [1:0]       Branch,
    input  logic [LUT_W-1:0] targetLUT,
    input  logic             cond,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_en,
    output logic             done
);

    localparam logic [PC_W-1:0] END_PC = PC_W'(PROG_END);

    fetch_state_e    state;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] next_pc;

    branch_lut #(.PC_W(PC_W), .LUT_W(LUT_W)) u_lut (
        .idx  (targetLUT),
        .addr (target)
    );

    always_comb begin
        next_pc = pc + PC_W'(1);
        if (branch_taken(Branch, cond)) next_pc = target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_RUN;
                        pc    <= '0;
                    end
                end
                ST_RUN: begin
                    // The last instruction's branch is dropped; pc parks at PROG_END.
                    if (!stall) begin
                        if (pc == END_PC) state <= ST_DONE;
                        else              pc    <= next_pc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    pc    <= '0;
                end
            endcase
        end
    end

    assign fetch_en = (state == ST_RUN);
    assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: four parameterisations driven in parallel against a reference model.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stall = 1'b0, cond = 1'b0;
    logic [1:0] br = 2'b00;
    logic [3:0] tl = 4'd0;

    logic [9:0] pc_a, pc_b;
    logic [3:0] pc_c, pc_d;
    logic       fe_a, fe_b, fe_c, fe_d;
    logic       dn_a, dn_b, dn_c, dn_d;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(10), .PROG_END(1023), .LUT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .Branch(br),
        .targetLUT(tl), .cond(cond), .pc(pc_a), .fetch_en(fe_a), .done(dn_a));
    fetch_unit #(.PC_W(10), .PROG_END(8), .LUT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .Branch(br),
        .targetLUT(tl), .cond(cond), .pc(pc_b), .fetch_en(fe_b), .done(dn_b));
    fetch_unit #(.PC_W(4), .PROG_END(15), .LUT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .Branch(br),
        .targetLUT(tl), .cond(cond), .pc(pc_c), .fetch_en(fe_c), .done(dn_c));
    fetch_unit #(.PC_W(4), .PROG_END(3), .LUT_W(4)) dut_d (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .Branch(br),
        .targetLUT(tl), .cond(cond), .pc(pc_d), .fetch_en(fe_d), .done(dn_d));

    // Reference model: phase 0 idle, 1 running, 2 finished.
    int LUTV [16] = '{0, 20, 40, 8, 14, 3, 100, 1023, 512, 5, 17, 1, 200, 300, 7, 1000};
    int PW   [4]  = '{10, 10, 4, 4};
    int PE   [4]  = '{1023, 8, 15, 3};
    int m_pc [4];
    int m_ph [4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_pc[k] = 0;
            m_ph[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            int  span;
            bit  jump;
            span = 1 << PW[k];
            jump = (br == 2'b11) || (br == 2'b01 && cond) || (br == 2'b10 && !cond);
            if (m_ph[k] != 1) begin
                if (start) begin
                    m_ph[k] = 1;
                    m_pc[k] = 0;
                end
            end else if (!stall) begin
                if (m_pc[k] == PE[k]) m_ph[k] = 2;
                else if (jump)        m_pc[k] = LUTV[tl] % span;
                else                  m_pc[k] = (m_pc[k] + 1) % span;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a.pc", 32'(pc_a), 32'(m_pc[0])); chk("a.fe", 32'(fe_a), 32'(m_ph[0] == 1)); chk("a.done", 32'(dn_a), 32'(m_ph[0] == 2));
        chk("b.pc", 32'(pc_b), 32'(m_pc[1])); chk("b.fe", 32'(fe_b), 32'(m_ph[1] == 1)); chk("b.done", 32'(dn_b), 32'(m_ph[1] == 2));
        chk("c.pc", 32'(pc_c), 32'(m_pc[2])); chk("c.fe", 32'(fe_c), 32'(m_ph[2] == 1)); chk("c.done", 32'(dn_c), 32'(m_ph[2] == 2));
        chk("d.pc", 32'(pc_d), 32'(m_pc[3])); chk("d.fe", 32'(fe_d), 32'(m_ph[3] == 1)); chk("d.done", 32'(dn_d), 32'(m_ph[3] == 2));
    endtask

    task automatic step(input logic s, input logic sl, input logic [1:0] b, input logic [3:0] t, input logic c);
        start = s; stall = sl; br = b; tl = t; cond = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        start = 1'b0; stall = 1'b0; br = 2'b00; tl = 4'd0; cond = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       st;
        logic       sl;
        logic [1:0] b;
        logic [3:0] t;
        logic       c;
        int         e_pc;
        logic       e_fe;
        logic       e_dn;
    } vec_t;

    vec_t tv [22];

    initial begin
        int  guard;
        bit  seen;

        tv[0]  = '{1'b1, 1'b0, 2'd0, 4'd0, 1'b0,    0, 1'b1, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 2'd0, 4'd0, 1'b0,    1, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 1'b0, 2'd0, 4'd0, 1'b0,    2, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 2'd0, 4'd0, 1'b0,    3, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 2'd0, 4'd0, 1'b0,    4, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 2'd0, 4'd0, 1'b0,    5, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 2'd3, 4'd2, 1'b0,   40, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 2'd3, 4'd9, 1'b0,    5, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 2'd1, 4'd2, 1'b0,    6, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 2'd1, 4'd2, 1'b1,   40, 1'b1, 1'b0};
        tv[10] = '{1'b0, 1'b1, 2'd2, 4'd1, 1'b0,   40, 1'b1, 1'b0};
        tv[11] = '{1'b0, 1'b1, 2'd2, 4'd1, 1'b0,   40, 1'b1, 1'b0};
        tv[12] = '{1'b0, 1'b1, 2'd2, 4'd1, 1'b0,   40, 1'b1, 1'b0};
        tv[13] = '{1'b0, 1'b0, 2'd2, 4'd1, 1'b0,   20, 1'b1, 1'b0};
        tv[14] = '{1'b0, 1'b0, 2'd2, 4'd1, 1'b1,   21, 1'b1, 1'b0};
        tv[15] = '{1'b1, 1'b0, 2'd0, 4'd0, 1'b0,   22, 1'b1, 1'b0};
        tv[16] = '{1'b0, 1'b0, 2'd0, 4'd1, 1'b0,   23, 1'b1, 1'b0};
        tv[17] = '{1'b0, 1'b0, 2'd3, 4'd7, 1'b0, 1023, 1'b1, 1'b0};
        tv[18] = '{1'b0, 1'b0, 2'd3, 4'd2, 1'b0, 1023, 1'b0, 1'b1};
        tv[19] = '{1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1023, 1'b0, 1'b1};
        tv[20] = '{1'b1, 1'b0, 2'd0, 4'd0, 1'b0,    0, 1'b1, 1'b0};
        tv[21] = '{1'b0, 1'b0, 2'd0, 4'd0, 1'b0,    1, 1'b1, 1'b0};

        // Table sequence on the default-parameter instance.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(tv[i].st, tv[i].sl, tv[i].b, tv[i].t, tv[i].c);
            chk($sformatf("tv%0d.pc", i), 32'(pc_a), 32'(tv[i].e_pc));
            chk($sformatf("tv%0d.fe", i), 32'(fe_a), 32'(tv[i].e_fe));
            chk($sformatf("tv%0d.done", i), 32'(dn_a), 32'(tv[i].e_dn));
        end

        // Asynchronous reset between edges in the middle of a run.
        do_reset();
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        chk("mid.pc17", 32'(pc_a), 32'd17);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.pc", 32'(pc_a), 32'd0);
        chk("arst.fe", 32'(fe_a), 32'd0);
        chk("arst.done", 32'(dn_a), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'd3, 4'd2, 1'b1);
            chk("idle.fe", 32'(fe_a), 32'd0);
        end
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        chk("restart.fe", 32'(fe_a), 32'd1);

        // PROG_END=8 straight run, then restart from DONE.
        do_reset();
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        seen = 1'b0;
        guard = 0;
        while (!seen && guard < 20) begin
            if (pc_b == 10'd8 && fe_b) seen = 1'b1;
            else step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
            guard++;
        end
        chk("end8.reached", 32'(seen), 32'd1);
        step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        chk("end8.done", 32'(dn_b), 32'd1);
        chk("end8.pc", 32'(pc_b), 32'd8);
        step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        chk("end8.hold", 32'(pc_b), 32'd8);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        chk("end8.restart.pc", 32'(pc_b), 32'd0);
        chk("end8.restart.done", 32'(dn_b), 32'd0);

        // 4-bit PC: branch to 14, then 15 ends one instance and wraps the other.
        do_reset();
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 2'd3, 4'd4, 1'b0);
        chk("w.c14", 32'(pc_c), 32'd14);
        chk("w.d14", 32'(pc_d), 32'd14);
        step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        chk("w.c15", 32'(pc_c), 32'd15);
        chk("w.c15.done", 32'(dn_c), 32'd0);
        step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        chk("w.c.done", 32'(dn_c), 32'd1);
        chk("w.c.pc", 32'(pc_c), 32'd15);
        chk("w.d.wrap", 32'(pc_d), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        chk("w.d.done", 32'(dn_d), 32'd1);
        chk("w.d.pc", 32'(pc_d), 32'd3);

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10: program counter width in bits.
REQ-002 SHALL have parameter PROG_END, default 10'd1023: address whose fetch ends the run.
REQ-003 SHALL have parameter LUT_W, default 4: branch-target select width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins a program run at address 0.
REQ-007 SHALL have port stall, input, 1: holds the PC (memory busy).
REQ-008 SHALL have port Branch, input, 2: decoder branch kind (00 none, 01 jump if cond, 10 jump if !cond, 11 always).
REQ-009 SHALL have port targetLUT, input, LUT_W: branch-target table index from the decoder.
REQ-010 SHALL have port cond, input, 1: ALU condition flag, sampled in the same cycle as Branch.
REQ-011 SHALL have port pc, output, PC_W: current instruction address to instruction ROM.
REQ-012 SHALL have port fetch_en, output, 1: pc is valid; the decoder may act on the ROM word.
REQ-013 SHALL have port done, output, 1: run finished; held until the next start.

Function
REQ-014 SHALL implement the states IDLE, RUN and DONE, encoded as a 2-bit enum.
REQ-015 IDLE: pc=0, fetch_en=0, done=0; start moves to RUN with pc=0.
REQ-016 RUN: fetch_en=1; each cycle without stall, pc advances to next_pc.
REQ-017 next_pc SHALL be lut[targetLUT] when taken, else pc+1.
REQ-018 taken = (Branch==11) | (Branch==01 & cond) | (Branch==10 & !cond).
REQ-019 The lut SHALL be 2^LUT_W entries of PC_W-bit absolute addresses, constant after elaboration.
REQ-020 Stall SHALL hold pc and ignore Branch and cond that cycle; the decoder re-presents them because the instruction is unchanged.
REQ-021 When RUN has pc==PROG_END and no stall, the block SHALL move to DONE; that instruction's branch is ignored.
REQ-022 DONE: fetch_en=0, done=1, pc frozen at PROG_END.
REQ-023 start in DONE SHALL move to RUN with pc=0 and done=0 on the next cycle.
REQ-024 start in RUN SHALL be ignored.
REQ-025 pc+1 SHALL wrap modulo 2^PC_W, for example 1023 to 0 when PROG_END is elsewhere.
REQ-026 A branch target equal to PROG_END SHALL give DONE one non-stalled cycle after arrival.
REQ-027 Transition latency: start to fetch_en=1 SHALL be 1 cycle; PC update SHALL be 1 cycle; there are no combinational paths from inputs to pc or done.

Reset
REQ-028 rst_n low SHALL force IDLE, pc=0, fetch_en=0, done=0 immediately, regardless of clk.
REQ-029 Reset mid-RUN SHALL abandon the run; after rst_n rises the block waits for start.
REQ-030 Release of rst_n SHALL be assumed synchronous to clk by the integrator; no internal synchronizer is required.

Structure
REQ-031 The branch-kind codes (NONE, IF_COND, IF_NCOND, ALWAYS) and the state enum SHALL live in the shared package with the decoder's constants.
REQ-032 The target table SHALL be a sub-module branch_lut (index in, address out, combinational case table) shared with the assembler's label numbering.
REQ-033 The fetch_unit body SHALL hold the FSM and PC register only.

Verification
REQ-034 Scenario: reset, then start pulse -> pc 0,1,2,3 on successive cycles, fetch_en=1 from cycle 1.
REQ-035 Scenario: at pc=5, Branch=11, targetLUT=2, lut[2]=40 -> pc=40 next cycle; Branch=01 with cond=0 -> pc=6.
REQ-036 Scenario: Branch=10 with cond=0 and stall=1 for 3 cycles -> pc held 3 cycles, then jumps to the target.
REQ-037 Scenario: PROG_END=8, run straight -> done=1 the cycle after pc=8, pc stays 8; a second start -> pc=0, done=0.
REQ-038 Scenario: rst_n low mid-run at pc=17, between clock edges -> pc=0, fetch_en=0 immediately; stays IDLE until start.
REQ-039 Scenario: PC_W=4, PROG_END=15 unreachable through branches back to 14 -> 14,15 gives done; variant with PROG_END=3 and pc starting past it shows wrap 15 to 0.
